// File: rtl/riscv_alu.sv
// 32-bit RISC-V execute-stage ALU: combinational result/NZCV flags from one shared
// 33-bit adder, plus copies of both registered on the rising clock edge.
module riscv_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [3:0]  control,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic [31:0] result_q,
    output logic [3:0]  flags_q
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_PASSB = 4'b1010;
    localparam logic [3:0] OP_RSV0  = 4'b1011;
    localparam logic [3:0] OP_RSV1  = 4'b1100;
    localparam logic [3:0] OP_RSV2  = 4'b1101;
    localparam logic [3:0] OP_RSV3  = 4'b1110;
    localparam logic [3:0] OP_RSV4  = 4'b1111;

    logic        w_sub;
    logic        w_arith;
    logic [31:0] w_b_eff;
    logic [32:0] w_sum;
    logic        w_carry;
    logic        w_ovf;
    logic [4:0]  w_shamt;
    logic [31:0] w_result;
    logic [3:0]  w_flags;
    logic [31:0] r_result_q;
    logic [3:0]  r_flags_q;

    // SLT/SLTU reuse the subtractor so compares share the one adder.
    assign w_sub   = (control == OP_SUB) | (control == OP_SLT) | (control == OP_SLTU);
    assign w_arith = (control == OP_ADD) | w_sub;
    assign w_b_eff = operand2 ^ {32{w_sub}};
    assign w_sum   = {1'b0, operand1} + {1'b0, w_b_eff} + {32'd0, w_sub};
    assign w_carry = w_sum[32];
    assign w_ovf   = (operand1[31] == w_b_eff[31]) && (w_sum[31] != operand1[31]);
    assign w_shamt = operand2[4:0];

    // Result select; unknown op codes yield X rather than a masking default.
    always_comb begin
        w_result = 32'd0;
        case (control)
            OP_ADD:   w_result = w_sum[31:0];
            OP_SUB:   w_result = w_sum[31:0];
            OP_AND:   w_result = operand1 & operand2;
            OP_OR:    w_result = operand1 | operand2;
            OP_XOR:   w_result = operand1 ^ operand2;
            OP_SLT:   w_result = {31'd0, w_sum[31] ^ w_ovf};
            OP_SLTU:  w_result = {31'd0, ~w_carry};
            OP_SLL:   w_result = operand1 << w_shamt;
            OP_SRL:   w_result = operand1 >> w_shamt;
            OP_SRA:   w_result = $unsigned($signed(operand1) >>> w_shamt);
            OP_PASSB: w_result = operand2;
            OP_RSV0, OP_RSV1, OP_RSV2, OP_RSV3, OP_RSV4:
                      w_result = 32'd0;
            default:  w_result = {32{1'bx}};
        endcase
    end

    // NZCV: C and V only meaningful for adder-based ops, forced to 0 otherwise.
    always_comb begin
        w_flags    = 4'd0;
        w_flags[3] = w_result[31];
        w_flags[2] = (w_result == 32'd0);
        w_flags[1] = w_arith & w_carry;
        w_flags[0] = w_arith & w_ovf;
    end

    // Registered copies of result and flags for pipelined/debug consumers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_q <= 32'd0;
            r_flags_q  <= 4'd0;
        end else begin
            r_result_q <= w_result;
            r_flags_q  <= w_flags;
        end
    end

    assign result   = w_result;
    assign flags    = w_flags;
    assign result_q = r_result_q;
    assign flags_q  = r_flags_q;

endmodule

// File: tb/tb_riscv_alu.sv
// Directed self-checking bench for riscv_alu: combinational ops, NZCV boundaries,
// and the registered path including asynchronous reset behaviour.
module tb_riscv_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [3:0]  control;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [31:0] result_q;
    logic [3:0]  flags_q;

    int n_tests;
    int n_fails;

    riscv_alu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .operand1 (operand1),
        .operand2 (operand2),
        .control  (control),
        .result   (result),
        .flags    (flags),
        .result_q (result_q),
        .flags_q  (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        control  = op;
        operand1 = a;
        operand2 = b;
        #1;
    endtask

    task automatic comb(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input logic [3:0] exp_f);
        apply(op, a, b);
        chk32({tag, "_res"}, result, exp_r);
        chk4({tag, "_flg"}, flags, exp_f);
    endtask

    initial begin
        n_tests  = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        operand1 = 32'd0;
        operand2 = 32'd0;
        control  = 4'b0000;
        #12;
        chk32("rst_result_q", result_q, 32'h0000_0000);
        chk4("rst_flags_q", flags_q, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        comb("add_ovf",    4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
        comb("add_carry",  4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
        comb("add_plain",  4'b0000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 4'b0000);
        comb("sub_zero",   4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110);
        comb("sub_borrow", 4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000);
        comb("sub_ovf",    4'b0001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011);
        comb("and",        4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000);
        comb("or",         4'b0011, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 4'b1000);
        comb("xor",        4'b0100, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 4'b0100);
        comb("slt",        4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0010);
        comb("slt_ovf",    4'b0101, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 4'b0011);
        comb("sltu",       4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
        comb("sltu_lt",    4'b0110, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000);
        comb("sll_31",     4'b0111, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 4'b1000);
        comb("sll_0",      4'b0111, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 4'b0000);
        comb("sra",        4'b1001, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 4'b1000);
        comb("srl",        4'b1000, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 4'b0000);
        comb("passb",      4'b1010, 32'hDEAD_BEEF, 32'h8765_4000, 32'h8765_4000, 4'b1000);
        comb("rsv_b",      4'b1011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0100);
        comb("rsv_f",      4'b1111, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 4'b0100);

        @(negedge clk);
        apply(4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk32("q_before_edge", result_q, 32'h0000_0000);
        @(posedge clk);
        #1;
        chk32("q_and_result", result_q, 32'h00F0_00F0);
        chk4("q_and_flags", flags_q, 4'b0000);

        #2;
        rst_n = 1'b0;
        #1;
        chk32("q_async_clr_r", result_q, 32'h0000_0000);
        chk4("q_async_clr_f", flags_q, 4'b0000);
        chk32("comb_in_reset", result, 32'h00F0_00F0);
        @(posedge clk);
        #1;
        chk32("q_held_in_reset", result_q, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk32("q_after_release", result_q, 32'h0000_0000);
        @(posedge clk);
        #1;
        chk32("q_first_edge_r", result_q, 32'h00F0_00F0);
        chk4("q_first_edge_f", flags_q, 4'b0000);

        @(negedge clk);
        apply(4'b0001, 32'h0000_0000, 32'h0000_0001);
        @(posedge clk);
        #1;
        chk32("q_sub_result", result_q, 32'hFFFF_FFFF);
        chk4("q_sub_flags", flags_q, 4'b1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
